sw_debounce_ctrl: RTL and testbench

Memory-mapped controller that conditions the board slide-switch input before software reads it. It synchronizes the raw switch bus and debounces it with a programmable sample tick. It latches per-bit change events and raises a maskable interrupt. It sits between the switch pins and the Avalon-MM fabric, and gives software a stable switch value plus change notification.

---
 rtl/sw_debounce_ctrl.sv | 118 +++++++++++
 tb/tb_sw_debounce_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sw_debounce_ctrl.sv
// Avalon-MM slide-switch conditioner: 2-flop synchronizer, tick-sampled 3-deep debounce,
// per-bit change capture with write-1-to-clear and a maskable level interrupt.
module sw_debounce_ctrl #(
  parameter int          WIDTH          = 10,
  parameter logic [15:0] DEFAULT_PERIOD = 16'd50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] sync_meta;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] samp0;
  logic [WIDTH-1:0] samp1;
  logic [WIDTH-1:0] samp2;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_q;
  logic [15:0]      period;
  logic [15:0]      presc;

  logic             period_wr;
  logic             edge_wr;
  logic             mask_wr;
  logic [15:0]      period_eff;
  logic             tick;
  logic [WIDTH-1:0] settle_mask;
  logic [WIDTH-1:0] clear_mask;
  logic [WIDTH-1:0] edge_next;
  logic [31:0]      rd_next;
  logic             unused_wdata;

  // A bit settles when all three samples agree and disagree with the debounced value;
  // a set from settling overrides a simultaneous software clear.
  always_comb begin
    period_wr   = write && (address == 3'd3);
    edge_wr     = write && (address == 3'd2);
    mask_wr     = write && (address == 3'd1);
    period_eff  = (period == 16'd0) ? 16'd1 : period;
    tick        = !period_wr && (presc == (period_eff - 16'd1));
    settle_mask = ~(samp0 ^ samp1) & ~(samp1 ^ samp2) & (samp0 ^ data);
    clear_mask  = edge_wr ? writedata[WIDTH-1:0] : '0;
    edge_next   = (edge_q & ~clear_mask) | settle_mask;
    rd_next     = '0;
    case (address)
      3'd0:    rd_next[WIDTH-1:0] = data;
      3'd1:    rd_next[WIDTH-1:0] = irq_mask;
      3'd2:    rd_next[WIDTH-1:0] = edge_q;
      3'd3:    rd_next[15:0]      = period;
      3'd4:    rd_next[WIDTH-1:0] = sync;
      default: rd_next            = '0;
    endcase
  end

  assign unused_wdata = ^writedata[31:16];
  assign irq          = |(edge_q & irq_mask);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= '0;
      sync      <= '0;
    end else begin
      sync_meta <= in_port;
      sync      <= sync_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else if (period_wr || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      samp0 <= '0;
      samp1 <= '0;
      samp2 <= '0;
      data  <= '0;
    end else begin
      if (tick) begin
        samp0 <= sync;
        samp1 <= samp0;
        samp2 <= samp1;
      end
      data <= data ^ settle_mask;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_mask <= '0;
      edge_q   <= '0;
      period   <= DEFAULT_PERIOD;
      readdata <= '0;
    end else begin
      if (mask_wr) begin
        irq_mask <= writedata[WIDTH-1:0];
      end
      if (period_wr) begin
        period <= writedata[15:0];
      end
      edge_q   <= edge_next;
      readdata <= rd_next;
    end
  end

endmodule

// File: tb/tb_sw_debounce_ctrl.sv
// Self-checking bench for sw_debounce_ctrl: scoreboarded register reads, a register-map
// vector table, and timed sequences for debounce, glitch, W1C race, PERIOD=0 and reset.
module tb_sw_debounce_ctrl;

  logic        clk;
  logic        reset;
  logic [2:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [9:0]  in_port;
  logic        irq;

  int checks;
  int errors;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t vecs[8];

  sw_debounce_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .write     (write),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_write(input logic [2:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write     = 1'b1;
    @(posedge clk);
    #1;
    write     = 1'b0;
    writedata = '0;
  endtask

  // Expectation is queued when the address is driven and retired when readdata lands.
  task automatic read_check(input logic [2:0] a, input logic [31:0] e, input string n);
    sb_t item;
    address   = a;
    write     = 1'b0;
    item.exp  = e;
    item.name = n;
    sb_q.push_back(item);
    @(posedge clk);
    #1;
    item = sb_q.pop_front();
    check_output(item.name, readdata, item.exp);
  endtask

  initial begin
    bit found;
    bit glitch_bad;

    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    address   = '0;
    write     = 1'b0;
    writedata = '0;
    in_port   = '0;

    vecs[0] = '{3'd0, 32'hFFFF_FFFF, 32'h0000_0200, "map_data"};
    vecs[1] = '{3'd1, 32'hFFFF_FFFF, 32'h0000_03FF, "map_irqmask"};
    vecs[2] = '{3'd2, 32'hFFFF_FFFF, 32'h0000_0000, "map_edge"};
    vecs[3] = '{3'd3, 32'hFFFF_FFFF, 32'h0000_FFFF, "map_period"};
    vecs[4] = '{3'd4, 32'hFFFF_FFFF, 32'h0000_0200, "map_raw"};
    vecs[5] = '{3'd5, 32'hFFFF_FFFF, 32'h0000_0000, "map_addr5"};
    vecs[6] = '{3'd6, 32'hFFFF_FFFF, 32'h0000_0000, "map_addr6"};
    vecs[7] = '{3'd7, 32'hFFFF_FFFF, 32'h0000_0000, "map_addr7"};

    wait_cycles(2);
    check_output("reset_readdata", readdata, 32'h0);
    check_output("reset_irq", {31'b0, irq}, 32'h0);
    reset = 1'b0;
    read_check(3'd3, 32'd50000, "reset_period");
    read_check(3'd0, 32'h0, "reset_data");
    read_check(3'd1, 32'h0, "reset_irqmask");
    read_check(3'd2, 32'h0, "reset_edge");

    // Glitch: 6-cycle pulse on bit 3 with PERIOD=4 sees at most two ticks
    apply_write(3'd3, 32'd4);
    apply_write(3'd1, 32'h3FF);
    address    = 3'd0;
    glitch_bad = 1'b0;
    in_port    = 10'h008;
    for (int i = 0; i < 30; i++) begin
      if (i == 6) in_port = 10'h000;
      @(posedge clk);
      #1;
      if (readdata !== 32'h0 || irq !== 1'b0) glitch_bad = 1'b1;
    end
    check_output("glitch_data_irq_quiet", {31'b0, glitch_bad}, 32'h0);
    read_check(3'd2, 32'h0, "glitch_edge");
    apply_write(3'd1, 32'h0);

    // Clean debounce: DATA within 2+12+1 cycles, plus one for the readdata register
    address = 3'd0;
    in_port = 10'h001;
    found   = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      if (readdata === 32'h1) begin
        found = 1'b1;
        break;
      end
    end
    check_output("debounce_within_budget", {31'b0, found}, 32'h1);
    read_check(3'd0, 32'h1, "debounce_data");
    read_check(3'd2, 32'h1, "debounce_edge");
    check_output("debounce_irq_unmasked", {31'b0, irq}, 32'h0);
    apply_write(3'd1, 32'h1);
    check_output("debounce_irq_on_mask", {31'b0, irq}, 32'h1);

    // W1C race: the PERIOD write fixes the prescaler phase so the falling change lands at W+13
    apply_write(3'd3, 32'd4);
    in_port = 10'h000;
    wait_cycles(11);
    read_check(3'd0, 32'h1, "race_data_before");
    apply_write(3'd2, 32'h1);
    check_output("race_irq", {31'b0, irq}, 32'h1);
    read_check(3'd2, 32'h1, "race_edge_set_wins");
    read_check(3'd0, 32'h0, "race_data_after");

    // PERIOD=0 behaves as 1: DATA bit 9 changes on the 6th edge after in_port
    apply_write(3'd1, 32'h200);
    apply_write(3'd3, 32'd0);
    in_port = 10'h200;
    wait_cycles(5);
    check_output("p0_irq_before", {31'b0, irq}, 32'h0);
    wait_cycles(1);
    check_output("p0_irq_at_6", {31'b0, irq}, 32'h1);
    read_check(3'd0, 32'h200, "p0_data");
    read_check(3'd2, 32'h201, "p0_edge");
    read_check(3'd4, 32'h200, "p0_raw");

    for (int i = 0; i < 8; i++) apply_write(vecs[i].addr, vecs[i].wdata);
    for (int i = 0; i < 8; i++) read_check(vecs[i].addr, vecs[i].exp, vecs[i].name);
    check_output("map_irq_cleared", {31'b0, irq}, 32'h0);

    // Reset mid-debounce from DATA=0x3FF
    apply_write(3'd3, 32'd0);
    in_port = 10'h3FF;
    wait_cycles(10);
    read_check(3'd0, 32'h3FF, "pre_reset_data");
    check_output("pre_reset_irq", {31'b0, irq}, 32'h1);
    in_port = 10'h000;
    wait_cycles(3);
    #3;
    reset = 1'b1;
    #1;
    check_output("midreset_readdata", readdata, 32'h0);
    check_output("midreset_irq", {31'b0, irq}, 32'h0);
    wait_cycles(2);
    reset = 1'b0;
    read_check(3'd0, 32'h0, "post_reset_data");
    read_check(3'd2, 32'h0, "post_reset_edge");
    read_check(3'd1, 32'h0, "post_reset_irqmask");
    read_check(3'd3, 32'd50000, "post_reset_period");
    check_output("post_reset_irq", {31'b0, irq}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
